// File: rtl/pong_ball_engine_pkg.sv
// Shared types and default geometry for the pong ball/score engine.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  localparam int HOME_X_DEF      = 270;
  localparam int HOME_Y_DEF      = 300;
  localparam int LEFT_LIMIT_DEF  = 160;
  localparam int RIGHT_LIMIT_DEF = 430;
  localparam int BALL_DIM        = 50;

endpackage

// File: rtl/pong_ball_engine_if.sv
// Game-control bundle between the frame/timing side and the ball engine.
interface pong_ball_engine_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int SPEED_W = 8,
  parameter int SCORE_W = 8
) ();
  import pong_pkg::*;

  logic               screenEnd;
  logic               startGame;
  logic               player;
  logic [SPEED_W-1:0] moveSpeed;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic               point_left;
  logic               point_right;
  logic               game_over;
  logic               winner;

  modport master (
    output screenEnd, startGame, player, moveSpeed,
    input  ball_x, ball_y, left_score, right_score,
           point_left, point_right, game_over, winner
  );

  modport slave (
    input  screenEnd, startGame, player, moveSpeed,
    output ball_x, ball_y, left_score, right_score,
           point_left, point_right, game_over, winner
  );

endinterface

// File: rtl/pong_ball_engine_frame_down_counter.sv
// Loadable frame down-counter; counts screenEnd strobes and flags zero.
module frame_down_counter #(
  parameter int LOAD_VAL = 30,
  parameter int CNT_W    = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load has priority; decrement stops at zero so the counter never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(LOAD_VAL);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame pong game state: ball position, serve pause, scores, win detect.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for a startGame rising edge, ball parked home
// ST_SERVE    | ball frozen at home while the serve counter runs down
// ST_PLAY     | ball moves by one step per screenEnd
// ST_POINT    | one cycle after a score: re-home ball, check for a win
// ST_GAMEOVER | a side reached WIN_SCORE; wait for a new start edge
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int SPEED_W      = 8,
  parameter int SPEED_SHIFT  = 6,
  parameter int HOME_X       = HOME_X_DEF,
  parameter int HOME_Y       = HOME_Y_DEF,
  parameter int LEFT_LIMIT   = LEFT_LIMIT_DEF,
  parameter int RIGHT_LIMIT  = RIGHT_LIMIT_DEF,
  parameter int SCORE_W      = 8,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 30
) (
  input logic           clk,
  input logic           reset,
  pong_ball_engine_if.slave bus
);

  localparam logic [X_W-1:0]     HOME_XV  = X_W'(HOME_X);
  localparam logic [X_W:0]       LEFT_XV  = (X_W + 1)'(LEFT_LIMIT);
  localparam logic [X_W:0]       RIGHT_XV = (X_W + 1)'(RIGHT_LIMIT);
  localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [X_W-1:0]     ball_x_q, ball_x_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic               point_left_q, point_left_d;
  logic               point_right_q, point_right_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               start_prev_q;

  logic               start_rise;
  logic [X_W:0]       step;
  logic [X_W:0]       next_x;
  logic               left_miss;
  logic               right_miss;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  assign start_rise = bus.startGame & ~start_prev_q;

  // Candidate position one bit wider than ball_x so a leftward borrow is visible.
  always_comb begin
    step   = (X_W + 1)'(bus.moveSpeed >> SPEED_SHIFT);
    next_x = bus.player ? ({1'b0, ball_x_q} - step) : ({1'b0, ball_x_q} + step);
    // A borrow past zero is a ball that went off the left edge, not a huge X.
    left_miss  = (bus.player & next_x[X_W]) | (next_x < LEFT_XV);
    right_miss = ~left_miss & (next_x > RIGHT_XV);
  end

  frame_down_counter #(
    .LOAD_VAL (SERVE_FRAMES)
  ) u_serve_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    point_left_d  = 1'b0;
    point_right_d = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ball_x_d = HOME_XV;
        if (start_rise) begin
          left_score_d  = '0;
          right_score_d = '0;
          cnt_load      = 1'b1;
          state_d       = ST_SERVE;
        end
      end

      ST_SERVE: begin
        ball_x_d = HOME_XV;
        if (cnt_zero) begin
          state_d = bus.startGame ? ST_PLAY : ST_IDLE;
        end else if (bus.screenEnd) begin
          cnt_dec = 1'b1;
        end
      end

      ST_PLAY: begin
        if (bus.screenEnd) begin
          if (!bus.startGame) begin
            ball_x_d = HOME_XV;
            state_d  = ST_IDLE;
          end else if (left_miss) begin
            right_score_d = right_score_q + SCORE_W'(1);
            point_right_d = 1'b1;
            state_d       = ST_POINT;
          end else if (right_miss) begin
            left_score_d = left_score_q + SCORE_W'(1);
            point_left_d = 1'b1;
            state_d      = ST_POINT;
          end else begin
            ball_x_d = next_x[X_W-1:0];
          end
        end
      end

      ST_POINT: begin
        ball_x_d = HOME_XV;
        // Only the side that just scored can have reached the threshold.
        if (left_score_q == WIN_V) begin
          game_over_d = 1'b1;
          winner_d    = 1'b0;
          state_d     = ST_GAMEOVER;
        end else if (right_score_q == WIN_V) begin
          game_over_d = 1'b1;
          winner_d    = 1'b1;
          state_d     = ST_GAMEOVER;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_SERVE;
        end
      end

      ST_GAMEOVER: begin
        if (start_rise) begin
          left_score_d  = '0;
          right_score_d = '0;
          game_over_d   = 1'b0;
          cnt_load      = 1'b1;
          state_d       = ST_SERVE;
        end
      end

      default: begin
        ball_x_d = HOME_XV;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ball_x_q      <= HOME_XV;
      left_score_q  <= '0;
      right_score_q <= '0;
      point_left_q  <= 1'b0;
      point_right_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      start_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      point_left_q  <= point_left_d;
      point_right_q <= point_right_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      start_prev_q  <= bus.startGame;
    end
  end

  assign bus.ball_x      = ball_x_q;
  assign bus.ball_y      = Y_W'(HOME_Y);
  assign bus.left_score  = left_score_q;
  assign bus.right_score = right_score_q;
  assign bus.point_left  = point_left_q;
  assign bus.point_right = point_right_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: default instance plus a wide-X instance for the
// leftward-underflow case. Expected snapshots are queued per frame strobe.
module tb_pong_ball_engine;

  localparam int A_HOME  = 270;
  localparam int A_LL    = 160;
  localparam int A_RL    = 430;
  localparam int A_SHIFT = 6;
  localparam int A_SERVE = 30;
  localparam int A_WIN   = 7;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_OVER  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_ball_engine_if #(.X_W(10), .Y_W(9), .SPEED_W(8), .SCORE_W(8)) bus_a ();
  pong_ball_engine_if #(.X_W(11), .Y_W(9), .SPEED_W(8), .SCORE_W(8)) bus_b ();

  pong_ball_engine #(.SERVE_FRAMES(A_SERVE)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pong_ball_engine #(
    .X_W          (11),
    .SPEED_SHIFT  (2),
    .HOME_X       (600),
    .LEFT_LIMIT   (5),
    .RIGHT_LIMIT  (1000),
    .SERVE_FRAMES (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    int bx;
    int ls;
    int rs;
    int pl;
    int pr;
    int go;
  } snap_t;

  snap_t sb[$];
  int n_total = 0;
  int n_bad   = 0;

  int m_phase, m_cnt, m_x, m_ls, m_rs, m_win, m_go;
  bit m_prev;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic snap_t mk(int bx, int ls, int rs, int pl, int pr, int go);
    snap_t s;
    s.bx = bx; s.ls = ls; s.rs = rs; s.pl = pl; s.pr = pr; s.go = go;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_snap(input string tag, input longint bx, input longint ls,
                            input longint rs, input longint pl, input longint pr,
                            input longint go);
    snap_t s;
    s = sb.pop_front();
    chk({tag, "_ball_x"}, bx, s.bx);
    chk({tag, "_lscore"}, ls, s.ls);
    chk({tag, "_rscore"}, rs, s.rs);
    chk({tag, "_pt_left"}, pl, s.pl);
    chk({tag, "_pt_right"}, pr, s.pr);
    chk({tag, "_game_over"}, go, s.go);
  endtask

  task automatic model_reset_a();
    m_phase = PH_IDLE; m_cnt = 0; m_x = A_HOME;
    m_ls = 0; m_rs = 0; m_go = 0; m_win = 0; m_prev = 1'b0;
  endtask

  task automatic set_start_a(input bit v);
    bus_a.startGame = v;
    if (v && !m_prev && (m_phase == PH_IDLE || m_phase == PH_OVER)) begin
      m_ls = 0; m_rs = 0; m_go = 0;
      m_phase = PH_SERVE; m_cnt = A_SERVE;
    end
    m_prev = v;
    tick();
    tick();
  endtask

  // One frame strobe on instance A: predict, queue two snapshots (the cycle
  // after the strobe and the cycle after that), drive, then compare.
  task automatic frame_a(output bit scored);
    snap_t s1, s2;
    int step, nx, pl, pr, go_before;
    scored = 1'b0; pl = 0; pr = 0; go_before = m_go;
    case (m_phase)
      PH_SERVE: begin
        m_cnt--;
        if (m_cnt == 0) m_phase = bus_a.startGame ? PH_PLAY : PH_IDLE;
      end
      PH_PLAY: begin
        if (!bus_a.startGame) begin
          m_phase = PH_IDLE;
          m_x = A_HOME;
        end else begin
          step = int'(bus_a.moveSpeed) >> A_SHIFT;
          nx = bus_a.player ? m_x - step : m_x + step;
          if (nx < A_LL) begin m_rs++; pr = 1; end
          else if (nx > A_RL) begin m_ls++; pl = 1; end
          else m_x = nx;
        end
      end
      default: ;
    endcase
    s1 = mk(m_x, m_ls, m_rs, pl, pr, go_before);
    if (pl != 0 || pr != 0) begin
      scored = 1'b1;
      m_x = A_HOME;
      if (m_ls == A_WIN || m_rs == A_WIN) begin
        m_phase = PH_OVER; m_go = 1; m_win = (m_rs == A_WIN) ? 1 : 0;
      end else begin
        m_phase = PH_SERVE; m_cnt = A_SERVE;
      end
    end
    s2 = mk(m_x, m_ls, m_rs, 0, 0, m_go);
    sb.push_back(s1);
    sb.push_back(s2);
    bus_a.screenEnd = 1'b1;
    tick();
    bus_a.screenEnd = 1'b0;
    check_snap("a1", bus_a.ball_x, bus_a.left_score, bus_a.right_score,
               bus_a.point_left, bus_a.point_right, bus_a.game_over);
    tick();
    check_snap("a2", bus_a.ball_x, bus_a.left_score, bus_a.right_score,
               bus_a.point_left, bus_a.point_right, bus_a.game_over);
    tick();
    tick();
  endtask

  task automatic run_a(input int n);
    bit sc;
    for (int i = 0; i < n; i++) frame_a(sc);
  endtask

  task automatic run_until_point_a(input string tag, input int max_frames);
    bit sc;
    int i;
    sc = 1'b0;
    for (i = 0; i < max_frames && !sc; i++) frame_a(sc);
    chk({tag, "_point_seen"}, sc, 1);
  endtask

  task automatic frame_b(input snap_t s1, input snap_t s2);
    sb.push_back(s1);
    sb.push_back(s2);
    bus_b.screenEnd = 1'b1;
    tick();
    bus_b.screenEnd = 1'b0;
    check_snap("b1", bus_b.ball_x, bus_b.left_score, bus_b.right_score,
               bus_b.point_left, bus_b.point_right, bus_b.game_over);
    tick();
    check_snap("b2", bus_b.ball_x, bus_b.left_score, bus_b.right_score,
               bus_b.point_left, bus_b.point_right, bus_b.game_over);
    tick();
    tick();
  endtask

  initial begin
    int x, nx, pts;
    bit done;

    reset = 1'b1;
    bus_a.screenEnd = 1'b0; bus_a.startGame = 1'b0; bus_a.player = 1'b0; bus_a.moveSpeed = '0;
    bus_b.screenEnd = 1'b0; bus_b.startGame = 1'b0; bus_b.player = 1'b0; bus_b.moveSpeed = '0;
    model_reset_a();
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_ball_x", bus_a.ball_x, A_HOME);
    chk("rst_ball_y", bus_a.ball_y, 300);
    chk("rst_lscore", bus_a.left_score, 0);
    chk("rst_rscore", bus_a.right_score, 0);
    chk("rst_pulses", {bus_a.point_left, bus_a.point_right}, 0);
    chk("rst_game_over", bus_a.game_over, 0);
    chk("rst_winner", bus_a.winner, 0);
    chk("rst_b_ball_x", bus_b.ball_x, 600);

    // Serve then rightward play at step 2 until left scores.
    bus_a.player = 1'b0; bus_a.moveSpeed = 8'd128;
    set_start_a(1'b1);
    run_until_point_a("left_first", 200);
    chk("left_first_lscore", bus_a.left_score, 1);

    // Leftward play at step 3 until right scores.
    bus_a.player = 1'b1; bus_a.moveSpeed = 8'd255;
    run_until_point_a("right_first", 200);
    chk("right_first_rscore", bus_a.right_score, 1);

    // Step 0: ball parked, no points.
    bus_a.moveSpeed = 8'd63;
    run_a(A_SERVE + 100);
    chk("step0_ball_x", bus_a.ball_x, A_HOME);
    chk("step0_lscore", bus_a.left_score, 1);

    // Left scores until the win threshold.
    bus_a.player = 1'b0; bus_a.moveSpeed = 8'd255;
    pts = 0;
    while (m_phase != PH_OVER && pts < 10) begin
      run_until_point_a("to_win", 200);
      pts++;
    end
    chk("win_game_over", bus_a.game_over, 1);
    chk("win_winner", bus_a.winner, m_win);
    chk("win_lscore", bus_a.left_score, A_WIN);
    run_a(5);
    chk("over_hold_lscore", bus_a.left_score, A_WIN);

    // Restart from game over.
    set_start_a(1'b0);
    set_start_a(1'b1);
    chk("restart_lscore", bus_a.left_score, 0);
    chk("restart_rscore", bus_a.right_score, 0);
    chk("restart_game_over", bus_a.game_over, 0);

    // Score once, play a little, then drop startGame mid-play.
    run_until_point_a("pre_drop", 200);
    run_a(A_SERVE + 5);
    set_start_a(1'b0);
    run_a(1);
    chk("drop_ball_x", bus_a.ball_x, A_HOME);
    chk("drop_lscore_kept", bus_a.left_score, 1);

    // Restart, score, and hit reset asynchronously during the serve pause.
    set_start_a(1'b1);
    run_until_point_a("pre_reset", 200);
    run_a(3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_ball_x", bus_a.ball_x, A_HOME);
    chk("async_lscore", bus_a.left_score, 0);
    chk("async_rscore", bus_a.right_score, 0);
    chk("async_pulses", {bus_a.point_left, bus_a.point_right}, 0);
    chk("async_game_over", bus_a.game_over, 0);
    chk("async_winner", bus_a.winner, 0);
    bus_a.startGame = 1'b0;
    model_reset_a();
    tick();
    reset = 1'b0;
    tick();
    run_a(3);

    // Wide-X instance: leftward step 63 from 600 wraps below zero.
    bus_b.player = 1'b1; bus_b.moveSpeed = 8'd255;
    bus_b.startGame = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) frame_b(mk(600, 0, 0, 0, 0, 0), mk(600, 0, 0, 0, 0, 0));
    x = 600;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      nx = x - 63;
      if (nx < 5) begin
        frame_b(mk(x, 0, 1, 0, 1, 0), mk(600, 0, 1, 0, 0, 0));
        done = 1'b1;
      end else begin
        frame_b(mk(nx, 0, 0, 0, 0, 0), mk(nx, 0, 0, 0, 0, 0));
        x = nx;
      end
    end
    chk("b_wrap_point_seen", done, 1);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
